// File: rtl/seq_det_prog_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_prog_pkg
// Shared types for the programmable serial pattern detector.
//   state_t    : detector FSM state (S_IDLE, S_FILL, S_DET), 2 bits wide
//   len_legal  : range check used when a new configuration is offered
// ---------------------------------------------------------------------------
package seq_det_prog_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DET  = 2'd2
  } state_t;

  // A pattern length is usable when it is 1..max_len inclusive.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_prog_cmp.sv
// ---------------------------------------------------------------------------
// seq_det_prog_cmp
// Combinational, length-limited compare of the candidate history against the
// stored pattern. Only bit positions below i_len take part; positions with a
// zero in i_mask are don't-care.
// Ports:
//   i_hist_nx  in  PAT_W  history including the bit being accepted (bit0 newest)
//   i_pat      in  PAT_W  stored pattern
//   i_mask     in  PAT_W  per-bit compare enable (all ones when masking is off)
//   i_len      in  LEN_W  active pattern length
//   o_hit_raw  out 1      all active, enabled bits agree
// ---------------------------------------------------------------------------
module seq_det_prog_cmp #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic [PAT_W-1:0] i_hist_nx,
  input  logic [PAT_W-1:0] i_pat,
  input  logic [PAT_W-1:0] i_mask,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_hit_raw
);

  always_comb begin
    o_hit_raw = 1'b1;
    for (int i = 0; i < PAT_W; i++) begin
      if ((LEN_W'(i) < i_len) && i_mask[i] && (i_hist_nx[i] != i_pat[i])) begin
        o_hit_raw = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// ---------------------------------------------------------------------------
// seq_det_prog
// Runtime-programmable serial bit-pattern detector (sync word / preamble).
// Optional feature macro: SEQ_DET_PROG_MASK_EN adds pat_mask (don't-care bits).
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   in         in   1      serial data bit
//   in_valid   in   1      qualifies in
//   cfg_load   in   1      pulse: latch pattern / pat_len / overlap (/ pat_mask)
//   pattern    in   PAT_W  bit[pat_len-1] oldest, bit[0] newest
//   pat_len    in   LEN_W  1..PAT_W
//   overlap    in   1      1 = overlapping matches allowed
//   pat_mask   in   PAT_W  (SEQ_DET_PROG_MASK_EN only) 0 = don't-care bit
//   cnt_clr    in   1      synchronous clear of match_cnt
//   out        out  1      registered match pulse
//   match_cnt  out  CNT_W  saturating match count
//   cfg_err    out  1      pulse: configuration rejected
//   armed      out  1      a valid configuration is held
// ---------------------------------------------------------------------------
module seq_det_prog
  import seq_det_prog_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
`ifdef SEQ_DET_PROG_MASK_EN
  input  logic [PAT_W-1:0] pat_mask,
`endif
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             armed
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [PAT_W-1:0]   r_hist;
  logic [PAT_W-1:0]   w_hist_nx;
  logic [PAT_W-1:0]   w_shift;
  logic [LEN_W-1:0]   r_fill;
  logic [LEN_W-1:0]   w_fill_nx;
  logic [LEN_W:0]     w_fill_p1;
  logic [PAT_W-1:0]   r_pat;
  logic [PAT_W-1:0]   r_mask;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cfg_err;
  logic               w_len_ok;
  logic               w_hit_raw;
  logic               w_hit;

  assign w_shift   = {r_hist[PAT_W-2:0], in};
  assign w_fill_p1 = {1'b0, r_fill} + 1'b1;
  assign w_len_ok  = len_legal(32'(pat_len), PAT_W);

  seq_det_prog_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .i_hist_nx (w_shift),
    .i_pat     (r_pat),
    .i_mask    (r_mask),
    .i_len     (r_len),
    .o_hit_raw (w_hit_raw)
  );

  // A new configuration always takes priority over the data bit of the same
  // cycle; the bit is dropped so no stale hit can be reported against the
  // pattern that is being replaced.
  always_comb begin
    w_state_nx = r_state;
    w_hist_nx  = r_hist;
    w_fill_nx  = r_fill;
    w_hit      = 1'b0;
    if (cfg_load) begin
      if (w_len_ok) begin
        w_state_nx = S_FILL;
        w_hist_nx  = '0;
        w_fill_nx  = '0;
      end
    end else if (in_valid && (r_state != S_IDLE)) begin
      w_hist_nx = w_shift;
      w_fill_nx = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
      if ((w_fill_p1 >= {1'b0, r_len}) && w_hit_raw) begin
        w_hit = 1'b1;
        if (r_ovl) begin
          w_state_nx = S_DET;
        end else begin
          // Non-overlapping: the next match must be built from fresh bits.
          w_state_nx = S_FILL;
          w_fill_nx  = '0;
        end
      end else if ((r_state == S_FILL) && (w_fill_p1 == {1'b0, r_len})) begin
        w_state_nx = S_DET;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= '0;
      r_mask    <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_out     <= 1'b0;
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_hist    <= w_hist_nx;
      r_fill    <= w_fill_nx;
      r_out     <= w_hit;
      r_cfg_err <= cfg_load && !w_len_ok;
      if (cfg_load && w_len_ok) begin
        r_pat <= pattern;
        r_len <= pat_len;
        r_ovl <= overlap;
`ifdef SEQ_DET_PROG_MASK_EN
        r_mask <= pat_mask;
`else
        r_mask <= '1;
`endif
      end
      // Clear beats a coincident hit; the pulse on out is unaffected.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_hit && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out       = r_out;
  assign match_cnt = r_cnt;
  assign cfg_err   = r_cfg_err;
  assign armed     = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_det_prog.sv
module tb_seq_det_prog;

  logic       clk;
  logic       t_rst;
  logic       t_in;
  logic       t_vld;
  logic       t_cfg;
  logic [7:0] t_pat;
  logic [3:0] t_len;
  logic       t_ovl;
  logic       t_clr;
  logic       t_out;
  logic [7:0] t_cnt;
  logic       t_err;
  logic       t_armed;
`ifdef SEQ_DET_PROG_MASK_EN
  logic [7:0] t_mask;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q_out[$];
  int q_err[$];

  seq_det_prog #(.PAT_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (t_rst),
    .in        (t_in),
    .in_valid  (t_vld),
    .cfg_load  (t_cfg),
    .pattern   (t_pat),
    .pat_len   (t_len),
    .overlap   (t_ovl),
`ifdef SEQ_DET_PROG_MASK_EN
    .pat_mask  (t_mask),
`endif
    .cnt_clr   (t_clr),
    .out       (t_out),
    .match_cnt (t_cnt),
    .cfg_err   (t_err),
    .armed     (t_armed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // Monitor: pops the expected pulse cycle whenever the DUT pulses, and flags
  // any expected pulse whose cycle has passed unseen.
  always @(negedge clk) begin
    if (t_out) begin
      total++;
      if (q_out.size() == 0) begin
        bad++;
        $display("FAIL out_pulse: got pulse at cycle %0d, expected none", cyc);
      end else begin
        int e;
        e = q_out.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL out_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
    while (q_out.size() > 0 && q_out[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL out_missing: no pulse at cycle %0d (now %0d)", q_out[0], cyc);
      void'(q_out.pop_front());
    end
    if (t_err) begin
      total++;
      if (q_err.size() == 0) begin
        bad++;
        $display("FAIL cfg_err_pulse: got pulse at cycle %0d, expected none", cyc);
      end else begin
        int e;
        e = q_err.pop_front();
        if (e != cyc) begin
          bad++;
          $display("FAIL cfg_err_pulse: got pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
    while (q_err.size() > 0 && q_err[0] < cyc) begin
      total++;
      bad++;
      $display("FAIL cfg_err_missing: no pulse at cycle %0d (now %0d)", q_err[0], cyc);
      void'(q_err.pop_front());
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bit_in(input logic b, input logic v, input logic clr, input logic exp_hit);
    t_in  = b;
    t_vld = v;
    t_clr = clr;
    @(posedge clk);
    #1;
    if (exp_hit) q_out.push_back(cyc);
    t_in  = 1'b0;
    t_vld = 1'b0;
    t_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov,
                      input logic exp_err, input logic b, input logic v);
    t_pat = p;
    t_len = l;
    t_ovl = ov;
    t_cfg = 1'b1;
    t_in  = b;
    t_vld = v;
    @(posedge clk);
    #1;
    if (exp_err) q_err.push_back(cyc);
    t_cfg = 1'b0;
    t_in  = 1'b0;
    t_vld = 1'b0;
  endtask

  // Streams n bits, first bit from bits[n-1]; hits flags the bits that complete a match.
  task automatic stream(input int n, input logic [31:0] bits, input logic [31:0] hits);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i], 1'b1, 1'b0, hits[i]);
  endtask

  task automatic do_reset();
    t_rst = 1'b0;
    @(posedge clk);
    #1;
    t_rst = 1'b1;
  endtask

  initial begin
    t_rst = 1'b0;
    t_in  = 1'b0;
    t_vld = 1'b0;
    t_cfg = 1'b0;
    t_pat = 8'h00;
    t_len = 4'd0;
    t_ovl = 1'b0;
    t_clr = 1'b0;
`ifdef SEQ_DET_PROG_MASK_EN
    t_mask = 8'hFF;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'(t_out), 0);
    chk("reset_cnt", int'(t_cnt), 0);
    chk("reset_cfg_err", int'(t_err), 0);
    chk("reset_armed", int'(t_armed), 0);
    t_rst = 1'b1;
    bit_in(1'b1, 1'b1, 1'b0, 1'b0);  // idle: ignored

    // T1 overlap
    load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_armed", int'(t_armed), 1);
    stream(7, 32'b1101101, 32'b0001001);
    chk("t1_cnt", int'(t_cnt), 2);

    // T2 non-overlap (count carries over)
    load(8'b1101, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_cnt_kept", int'(t_cnt), 2);
    stream(7, 32'b1101101, 32'b0001000);
    chk("t2_cnt", int'(t_cnt), 3);
    bit_in(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_clr", int'(t_cnt), 0);

    // T3 rejected lengths from the unconfigured state
    do_reset();
    chk("t3_armed_rst", int'(t_armed), 0);
    load(8'b1111, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    load(8'b1111, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_armed", int'(t_armed), 0);
    stream(4, 32'b1111, 32'b0000);
    chk("t3_cnt", int'(t_cnt), 0);

    // T4 gaps between valid bits
    load(8'b101, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0, 1'b0);
    bit_in(1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1, 1'b1, 1'b0, 1'b1);
    bit_in(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_cnt", int'(t_cnt), 1);

    // T5 saturation and clear coincident with a hit
    load(8'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    bit_in(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_clr0", int'(t_cnt), 0);
    for (int k = 0; k < 300; k++) bit_in(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_sat", int'(t_cnt), 255);
    bit_in(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_clr_hit", int'(t_cnt), 0);
    chk("t5_out", int'(t_out), 1);

    // T6 reset mid-stream, then reload coincident with completing bit
    load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(6, 32'b110110, 32'b000100);
    chk("t6_cnt_pre", int'(t_cnt), 1);
    t_rst = 1'b0;
    #1;
    chk("t6_rst_out", int'(t_out), 0);
    chk("t6_rst_cnt", int'(t_cnt), 0);
    chk("t6_rst_armed", int'(t_armed), 0);
    @(posedge clk);
    #1;
    t_rst = 1'b1;
    load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    stream(3, 32'b110, 32'b000);
    load(8'b1101, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t6_reload_armed", int'(t_armed), 1);
    chk("t6_reload_cnt", int'(t_cnt), 0);
    stream(4, 32'b1101, 32'b0001);
    chk("t6_final_cnt", int'(t_cnt), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("out_queue_empty", q_out.size(), 0);
    chk("err_queue_empty", q_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
